cm0_dap_cdc_rx_hs: RTL and testbench

CM0_DAP_CDC_RX_HS -- requirements
Module: cm0_dap_cdc_rx_hs

---
 rtl/cm0_dap_cdc_defs.sv | 6 +
 rtl/cm0_dap_cdc_sync.sv | 20 ++
 rtl/cm0_dap_cdc_rx_hs.sv | 89 ++++++++
 tb/tb_cm0_dap_cdc_rx_hs.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cm0_dap_cdc_defs.sv
// Shared CDC handshake definitions for the DAP transmit and receive sides.
package cm0_dap_cdc_defs;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HOLD = 2'b01;
  localparam logic [1:0] ST_ACK  = 2'b10;
endpackage

// File: rtl/cm0_dap_cdc_sync.sv
// Plain flop-chain synchronizer; kept as its own module so CDC constraints can target it.
module cm0_dap_cdc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic D,
  output logic Q
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], D};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign Q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/cm0_dap_cdc_rx_hs.sv
// Receive side of a four-phase req/ack CDC handshake: captures unsynchronized
// data once the synchronized request is seen, hands it to a valid/ready consumer.
module cm0_dap_cdc_rx_hs
  import cm0_dap_cdc_defs::*;
#(
  parameter int PRESENT     = 1,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQASYNC,
  input  logic [WIDTH-1:0] DATAASYNC,
  input  logic             ENABLE,
  input  logic             READY,
  output logic             VALID,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             ACKOUT
);
  generate
    if (PRESENT != 0) begin : g_rx
      logic             req_s;
      logic [1:0]       state_q, state_d;
      logic             valid_q, valid_d;
      logic             ack_q, ack_d;
      logic [WIDTH-1:0] data_q, data_d;

      cm0_dap_cdc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (REQASYNC),
        .Q     (req_s)
      );

      // DATAASYNC is stable while the request is up, so it is only sampled on IDLE exit.
      always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        data_d  = data_q;
        case (state_q)
          ST_IDLE: if (req_s && ENABLE) begin
            data_d  = DATAASYNC;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
          ST_HOLD: if (valid_q && READY) begin
            valid_d = 1'b0;
            ack_d   = 1'b1;
            state_d = ST_ACK;
          end
          ST_ACK: if (!req_s) begin
            ack_d   = 1'b0;
            state_d = ST_IDLE;
          end
          default: begin
            valid_d = 1'b0;
            ack_d   = 1'b0;
            state_d = ST_IDLE;
          end
        endcase
      end

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          ack_q   <= 1'b0;
          data_q  <= '0;
        end else begin
          state_q <= state_d;
          valid_q <= valid_d;
          ack_q   <= ack_d;
          data_q  <= data_d;
        end
      end

      assign VALID   = valid_q;
      assign DATAOUT = data_q;
      assign ACKOUT  = ack_q;
    end else begin : g_absent
      logic unused_in;
      assign unused_in = ^{CLK, RESET, REQASYNC, DATAASYNC, ENABLE, READY};
      assign VALID   = 1'b0;
      assign DATAOUT = '0;
      assign ACKOUT  = 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_cm0_dap_cdc_rx_hs.sv
// Bench for cm0_dap_cdc_rx_hs: cycle-exact handshake checks plus a data scoreboard.
module tb_cm0_dap_cdc_rx_hs;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req, en, rdy;
  logic [W-1:0] din;
  logic         valid, ack;
  logic [W-1:0] dout;

  logic         np_req, np_en, np_rdy;
  logic [W-1:0] np_din;
  logic         np_valid, np_ack;
  logic [W-1:0] np_dout;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] sb_q[$];

  always #5 clk = ~clk;

  cm0_dap_cdc_rx_hs #(.PRESENT(1), .WIDTH(W), .SYNC_STAGES(2)) u_dut (
    .CLK(clk), .RESET(rst), .REQASYNC(req), .DATAASYNC(din), .ENABLE(en),
    .READY(rdy), .VALID(valid), .DATAOUT(dout), .ACKOUT(ack)
  );

  cm0_dap_cdc_rx_hs #(.PRESENT(0), .WIDTH(W), .SYNC_STAGES(2)) u_np (
    .CLK(clk), .RESET(rst), .REQASYNC(np_req), .DATAASYNC(np_din), .ENABLE(np_en),
    .READY(np_rdy), .VALID(np_valid), .DATAOUT(np_dout), .ACKOUT(np_ack)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every consumed word must match the oldest word the bench offered.
  always @(negedge clk) begin
    if (!rst && valid && rdy) begin
      if (sb_q.size() == 0) chk("sb_unexpected_valid", 32'd1, 32'd0);
      else chk("sb_data", {24'd0, dout}, {24'd0, sb_q.pop_front()});
    end
  end

  // Drop the request and expect ACKOUT to fall exactly three edges later.
  task automatic req_release(input string tag);
    req = 1'b0;
    tick();
    tick();
    chk({tag, "_ack_hold"}, {31'd0, ack}, 32'd1);
    tick();
    chk({tag, "_ack_fall"}, {31'd0, ack}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; en = 1'b1; rdy = 1'b1; din = '0;
    np_req = 1'b0; np_en = 1'b0; np_rdy = 1'b0; np_din = '0;
    tick();
    tick();
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_data", {24'd0, dout}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic transfer
    din = 8'hA5; sb_q.push_back(8'hA5); req = 1'b1;
    tick(); tick();
    chk("basic_valid_early", {31'd0, valid}, 32'd0);
    tick();
    chk("basic_valid_c3", {31'd0, valid}, 32'd1);
    chk("basic_data", {24'd0, dout}, 32'h0A5);
    chk("basic_ack_c3", {31'd0, ack}, 32'd0);
    tick();
    chk("basic_ack_c4", {31'd0, ack}, 32'd1);
    chk("basic_valid_c4", {31'd0, valid}, 32'd0);
    req_release("basic");
    chk("basic_data_kept", {24'd0, dout}, 32'h0A5);

    // Stall with consumer not ready; ENABLE dropping mid-transfer is ignored
    rdy = 1'b0; din = 8'hA5; sb_q.push_back(8'hA5); req = 1'b1;
    tick(); tick(); tick();
    chk("stall_valid", {31'd0, valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) en = 1'b0;
      tick();
      chk("stall_valid_hold", {31'd0, valid}, 32'd1);
      chk("stall_data_hold", {24'd0, dout}, 32'h0A5);
      chk("stall_ack_low", {31'd0, ack}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    chk("stall_ack_rise", {31'd0, ack}, 32'd1);
    req_release("stall");
    en = 1'b1;

    // Disabled: request pending but ENABLE low
    en = 1'b0; rdy = 1'b0; din = 8'h5A; req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("dis_valid_low", {31'd0, valid}, 32'd0);
      chk("dis_ack_low", {31'd0, ack}, 32'd0);
    end
    sb_q.push_back(8'h5A); en = 1'b1;
    tick();
    chk("dis_valid_rise", {31'd0, valid}, 32'd1);
    chk("dis_data", {24'd0, dout}, 32'h05A);
    rdy = 1'b1;
    tick();
    chk("dis_ack", {31'd0, ack}, 32'd1);
    req_release("dis");

    // Reset in ACK with the request still high
    din = 8'hC3; sb_q.push_back(8'hC3); req = 1'b1;
    tick(); tick(); tick(); tick();
    chk("rstm_ack_pre", {31'd0, ack}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstm_ack_async", {31'd0, ack}, 32'd0);
    chk("rstm_valid", {31'd0, valid}, 32'd0);
    chk("rstm_data", {24'd0, dout}, 32'd0);
    tick();
    sb_q.push_back(8'hC3); rst = 1'b0;
    tick(); tick();
    chk("rstm_valid_early", {31'd0, valid}, 32'd0);
    tick();
    chk("rstm_recap_valid", {31'd0, valid}, 32'd1);
    chk("rstm_recap_data", {24'd0, dout}, 32'h0C3);
    tick();
    chk("rstm_ack", {31'd0, ack}, 32'd1);

    // Back-to-back: re-raise in the cycle ACKOUT falls
    req = 1'b0;
    begin
      int budget = 10;
      while (ack && budget > 0) begin tick(); budget--; end
      chk("b2b_ack_fall_timeout", {31'd0, ack}, 32'd0);
    end
    din = 8'h3C; sb_q.push_back(8'h3C); req = 1'b1;
    tick(); tick();
    chk("b2b_valid_early", {31'd0, valid}, 32'd0);
    tick();
    chk("b2b_valid", {31'd0, valid}, 32'd1);
    chk("b2b_data", {24'd0, dout}, 32'h03C);
    tick();
    chk("b2b_ack", {31'd0, ack}, 32'd1);
    chk("b2b_valid_once", {31'd0, valid}, 32'd0);
    req_release("b2b");
    tick(); tick();
    chk("sb_drained", sb_q.size(), 32'd0);

    // Absent instance ignores all stimulus
    for (int i = 0; i < 40; i++) begin
      np_req = 1'($urandom); np_en = 1'($urandom); np_rdy = 1'($urandom);
      np_din = 8'($urandom);
      rst = (i == 20);
      tick();
      chk("np_outputs", {22'd0, np_valid, np_ack, np_dout}, 32'd0);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
